// File: rtl/apb_initiator25.sv
// Single-command APB initiator: accepts one request, runs SETUP + ACCESS
// on the APB side (no pready), then holds the response until it is taken.
module apb_initiator25 #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              pclk25,
  input  logic              p_reset25,
  input  logic              req_valid25,
  output logic              req_ready25,
  input  logic              req_write25,
  input  logic [ADDR_W-1:0] req_addr25,
  input  logic [DATA_W-1:0] req_wdata25,
  output logic              rsp_valid25,
  input  logic              rsp_ready25,
  output logic              rsp_write25,
  output logic [DATA_W-1:0] rsp_rdata25,
  output logic              psel25,
  output logic              penable25,
  output logic              pwrite25,
  output logic [ADDR_W-1:0] paddr25,
  output logic [DATA_W-1:0] pwdata25,
  input  logic [DATA_W-1:0] prdata25,
  output logic [15:0]       xfer_cnt25
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // State register
  always_ff @(posedge pclk25) begin
    if (p_reset25) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; requests outside IDLE are simply not looked at
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid25) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready25) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is a pure state decode, masked while reset is applied
  assign req_ready25 = (state == IDLE) && !p_reset25;

  // APB strobes and response valid are registered from the next state
  always_ff @(posedge pclk25) begin
    if (p_reset25) begin
      psel25      <= 1'b0;
      penable25   <= 1'b0;
      rsp_valid25 <= 1'b0;
    end else begin
      psel25      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable25   <= (state_nxt == ACCESS);
      rsp_valid25 <= (state_nxt == RESP);
    end
  end

  // Command latch: address/data/direction hold until the next accept
  always_ff @(posedge pclk25) begin
    if (p_reset25) begin
      pwrite25 <= 1'b0;
      paddr25  <= '0;
      pwdata25 <= '0;
    end else if ((state == IDLE) && req_valid25) begin
      pwrite25 <= req_write25;
      paddr25  <= req_addr25;
      pwdata25 <= req_wdata25;
    end
  end

  // Completion of ACCESS: capture response and count the transfer
  always_ff @(posedge pclk25) begin
    if (p_reset25) begin
      rsp_write25 <= 1'b0;
      rsp_rdata25 <= '0;
      xfer_cnt25  <= '0;
    end else if (state == ACCESS) begin
      rsp_write25 <= pwrite25;
      rsp_rdata25 <= pwrite25 ? '0 : prdata25;
      xfer_cnt25  <= xfer_cnt25 + CNT_W'(1);
    end
  end

endmodule
